// File: rtl/fu_pkg.sv
// Shared types and constants for the multiply functional unit.
// No logic; decode helper is purely combinational.
// No flow control here; the consumers own handshaking.
package fu_pkg;

    typedef enum logic [2:0] {
        MADD,
        MSUB,
        SMULH,
        UMULH,
        UNSUP
    } mul_op_e;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        FIN,
        WB
    } state_e;

    localparam logic [31:0] ENC_MASK  = 32'hFFE0_8000;
    localparam logic [31:0] ENC_MADD  = 32'h9B00_0000;
    localparam logic [31:0] ENC_MSUB  = 32'h9B00_8000;
    localparam logic [31:0] ENC_SMULH = 32'h9B40_0000;
    localparam logic [31:0] ENC_UMULH = 32'h9BC0_0000;

    // Map a raw encoding onto the operation it requests; anything unknown is UNSUP.
    function automatic mul_op_e decode_op(input logic [31:0] enc);
        logic [31:0] key;
        key = enc & ENC_MASK;
        if (key == ENC_MADD)       return MADD;
        else if (key == ENC_MSUB)  return MSUB;
        else if (key == ENC_SMULH) return SMULH;
        else if (key == ENC_UMULH) return UMULH;
        else                       return UNSUP;
    endfunction

endpackage

// File: rtl/mul_step.sv
// One radix-16 shift-add step: acc*16 + multiplicand*digit, 128-bit wide.
// Latency: purely combinational.
// Backpressure: none; the caller sequences the steps.
module mul_step (
    input  logic [127:0] acc,
    input  logic [63:0]  mcand,
    input  logic [3:0]   digit,
    output logic [127:0] acc_next
);

    logic [67:0] partial;

    // Digits arrive most-significant first, so the running sum shifts up one nibble per step.
    always_comb begin
        partial  = {4'b0, mcand} * {64'b0, digit};
        acc_next = {acc[123:0], 4'b0} + {60'b0, partial};
    end

endmodule

// File: rtl/mul_fu.sv
// Iterative 64x64 multiply unit for MADD/MSUB/SMULH/UMULH with PRF writeback.
// Latency: results and completion appear in the cycle after the 17th edge past issue.
// Backpressure: fu_ready drops while busy and in any cycle carrying an issue strobe.
module mul_fu
    import fu_pkg::*;
#(
    parameter int INST_ID_BITS = 6,
    parameter int PRN_BITS     = 6,
    parameter int MAX_OPERANDS = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    output logic                    fu_ready,
    input  logic                    inst_valid,
    input  logic [INST_ID_BITS-1:0] inst_id,
    input  logic [31:0]             inst,
    input  logic [63:0]             op [MAX_OPERANDS],
    input  logic [PRN_BITS-1:0]     out_prn [MAX_OPERANDS],
    input  logic [63:0]             pc,
    output logic                    prf_write_enable,
    output logic [PRN_BITS-1:0]     prf_write_prn,
    output logic [63:0]             prf_write_data,
    output logic                    set_prn_ready [MAX_OPERANDS],
    output logic [PRN_BITS-1:0]     set_prn [MAX_OPERANDS],
    output logic                    done_valid,
    output logic [INST_ID_BITS-1:0] done_inst_id,
    output logic                    done_fault,
    output logic [63:0]             done_pc
);

    state_e                    state;
    logic [3:0]                cnt;
    logic [127:0]              acc;
    logic [127:0]              acc_next;
    logic [63:0]               mcand;
    logic [63:0]               mplier;
    logic [63:0]               addend;
    logic [63:0]               pc_q;
    logic [INST_ID_BITS-1:0]   id_q;
    logic [PRN_BITS-1:0]       prn_q;
    logic [4:0]                rd_q;
    mul_op_e                   op_q;
    logic                      neg_q;

    mul_op_e                   dec_op;
    logic                      is_signed;
    logic [63:0]               mag0;
    logic [63:0]               mag1;
    logic [127:0]              prod;
    logic [63:0]               result;
    logic                      do_write;
    logic                      unused_prn;

    assign fu_ready = (state == IDLE) && !inst_valid;

    mul_step u_step (
        .acc      (acc),
        .mcand    (mcand),
        .digit    (mplier[63:60]),
        .acc_next (acc_next)
    );

    // Decode at issue and fold signed operands to magnitudes; 2^63 survives as an unsigned magnitude.
    always_comb begin
        dec_op    = decode_op(inst);
        is_signed = (dec_op == SMULH);
        mag0      = (is_signed && op[0][63]) ? (~op[0] + 64'd1) : op[0];
        mag1      = (is_signed && op[1][63]) ? (~op[1] + 64'd1) : op[1];
    end

    // Apply the sign to the full product, then pick the architectural 64-bit result.
    always_comb begin
        prod     = neg_q ? (~acc + 128'd1) : acc;
        do_write = (op_q != UNSUP) && (rd_q != 5'd31);
        case (op_q)
            MADD:    result = addend + prod[63:0];
            MSUB:    result = addend - prod[63:0];
            SMULH,
            UMULH:   result = prod[127:64];
            default: result = 64'd0;
        endcase
    end

    // Only destination slot 0 is ever written; the remaining slots are accepted but unused.
    always_comb begin
        unused_prn = 1'b0;
        for (int k = 1; k < MAX_OPERANDS; k++) begin
            unused_prn = unused_prn ^ (^out_prn[k]);
        end
    end

    // Sequencer: capture on issue, 16 multiply steps, finalize, one-cycle writeback/completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            cnt              <= 4'd0;
            acc              <= '0;
            mcand            <= '0;
            mplier           <= '0;
            addend           <= '0;
            pc_q             <= '0;
            id_q             <= '0;
            prn_q            <= '0;
            rd_q             <= '0;
            op_q             <= UNSUP;
            neg_q            <= 1'b0;
            prf_write_enable <= 1'b0;
            prf_write_prn    <= '0;
            prf_write_data   <= '0;
            done_valid       <= 1'b0;
            done_inst_id     <= '0;
            done_fault       <= 1'b0;
            done_pc          <= '0;
            for (int k = 0; k < MAX_OPERANDS; k++) begin
                set_prn_ready[k] <= 1'b0;
                set_prn[k]       <= '0;
            end
        end else begin
            // Outputs live only for the single WB cycle following FIN.
            prf_write_enable <= 1'b0;
            prf_write_prn    <= '0;
            prf_write_data   <= '0;
            done_valid       <= 1'b0;
            done_inst_id     <= '0;
            done_fault       <= 1'b0;
            done_pc          <= '0;
            for (int k = 0; k < MAX_OPERANDS; k++) begin
                set_prn_ready[k] <= 1'b0;
                set_prn[k]       <= '0;
            end

            case (state)
                IDLE: begin
                    if (inst_valid) begin
                        op_q   <= dec_op;
                        rd_q   <= inst[4:0];
                        id_q   <= inst_id;
                        prn_q  <= out_prn[0];
                        pc_q   <= pc;
                        addend <= op[2];
                        mcand  <= mag0;
                        mplier <= mag1;
                        neg_q  <= is_signed && (op[0][63] ^ op[1][63]);
                        acc    <= '0;
                        cnt    <= 4'd0;
                        state  <= MUL;
                    end
                end
                MUL: begin
                    acc    <= acc_next;
                    mplier <= {mplier[59:0], 4'b0};
                    cnt    <= cnt + 4'd1;
                    if (cnt == 4'd15) begin
                        state <= FIN;
                    end
                end
                FIN: begin
                    done_valid   <= 1'b1;
                    done_inst_id <= id_q;
                    done_fault   <= (op_q == UNSUP);
                    done_pc      <= pc_q;
                    if (do_write) begin
                        prf_write_enable <= 1'b1;
                        prf_write_prn    <= prn_q;
                        prf_write_data   <= result;
                        set_prn_ready[0] <= 1'b1;
                        set_prn[0]       <= prn_q;
                    end
                    state <= WB;
                end
                WB: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_fu.sv
// Self-checking bench for mul_fu: directed vector table, hand sequences, random vs model.
// Latency: expects completion exactly one cycle after the 17th edge past issue.
// Backpressure: checks fu_ready around every issue.
module tb_mul_fu;

    localparam int IB = 6;
    localparam int PB = 6;
    localparam int NO = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          fu_ready;
    logic          inst_valid;
    logic [IB-1:0] inst_id;
    logic [31:0]   inst;
    logic [63:0]   op [NO];
    logic [PB-1:0] out_prn [NO];
    logic [63:0]   pc;
    logic          prf_write_enable;
    logic [PB-1:0] prf_write_prn;
    logic [63:0]   prf_write_data;
    logic          set_prn_ready [NO];
    logic [PB-1:0] set_prn [NO];
    logic          done_valid;
    logic [IB-1:0] done_inst_id;
    logic          done_fault;
    logic [63:0]   done_pc;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    mul_fu #(.INST_ID_BITS(IB), .PRN_BITS(PB), .MAX_OPERANDS(NO)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .fu_ready         (fu_ready),
        .inst_valid       (inst_valid),
        .inst_id          (inst_id),
        .inst             (inst),
        .op               (op),
        .out_prn          (out_prn),
        .pc               (pc),
        .prf_write_enable (prf_write_enable),
        .prf_write_prn    (prf_write_prn),
        .prf_write_data   (prf_write_data),
        .set_prn_ready    (set_prn_ready),
        .set_prn          (set_prn),
        .done_valid       (done_valid),
        .done_inst_id     (done_inst_id),
        .done_fault       (done_fault),
        .done_pc          (done_pc)
    );

    typedef struct {
        logic [31:0]   inst;
        logic [63:0]   a;
        logic [63:0]   b;
        logic [63:0]   c;
        logic [PB-1:0] prn;
        logic          we;
        logic [63:0]   data;
        logic          fault;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: actual=%h required=%h", name, act, exp);
    endtask

    // Reference: architectural meaning of each encoding using full-width arithmetic.
    function automatic vec_t model(input logic [31:0] i, input logic [63:0] a, input logic [63:0] b,
                                   input logic [63:0] c, input logic [PB-1:0] prn);
        vec_t               v;
        logic [127:0]       up;
        logic signed [127:0] sp;
        logic [31:0]        key;
        v.inst = i; v.a = a; v.b = b; v.c = c; v.prn = prn;
        v.fault = 1'b0;
        v.data  = 64'd0;
        key = i & 32'hFFE08000;
        up  = {64'd0, a} * {64'd0, b};
        sp  = $signed({{64{a[63]}}, a}) * $signed({{64{b[63]}}, b});
        case (key)
            32'h9B000000: v.data = c + up[63:0];
            32'h9B008000: v.data = c - up[63:0];
            32'h9B400000: v.data = sp[127:64];
            32'h9BC00000: v.data = up[127:64];
            default:      v.fault = 1'b1;
        endcase
        v.we = !v.fault && (i[4:0] != 5'd31);
        return v;
    endfunction

    task automatic drive_issue(input vec_t v, input logic [IB-1:0] id, input logic [63:0] pcv);
        inst_valid = 1'b1;
        inst       = v.inst;
        op[0]      = v.a;
        op[1]      = v.b;
        op[2]      = v.c;
        out_prn[0] = v.prn;
        inst_id    = id;
        pc         = pcv;
    endtask

    // Issue one instruction, optionally fire a stray strobe mid-multiply, then check WB.
    task automatic run_vec(input vec_t v, input logic [IB-1:0] id, input logic [63:0] pcv,
                           input string tag, input int dup_at);
        logic early;
        @(negedge clk);
        chk({tag, " ready_before"}, {63'd0, fu_ready}, 64'd1);
        drive_issue(v, id, pcv);
        #1 chk({tag, " ready_same_cycle"}, {63'd0, fu_ready}, 64'd0);
        @(posedge clk);
        #1;
        inst_valid = 1'b0;
        op[0] = {$urandom, $urandom};
        op[1] = {$urandom, $urandom};
        op[2] = {$urandom, $urandom};
        out_prn[0] = PB'($urandom);
        pc = {$urandom, $urandom};
        early = 1'b0;
        for (int k = 0; k < 16; k++) begin
            if (k == dup_at) begin
                inst_valid = 1'b1;
                inst_id    = id ^ 6'h01;
                inst       = 32'h9B000005;
            end
            @(posedge clk);
            #1;
            inst_valid = 1'b0;
            if (done_valid || prf_write_enable || set_prn_ready[0] || fu_ready) early = 1'b1;
        end
        chk({tag, " quiet_while_busy"}, {63'd0, early}, 64'd0);
        @(posedge clk);
        #1;
        chk({tag, " done_valid"}, {63'd0, done_valid}, 64'd1);
        chk({tag, " done_inst_id"}, {58'd0, done_inst_id}, {58'd0, id});
        chk({tag, " done_fault"}, {63'd0, done_fault}, {63'd0, v.fault});
        chk({tag, " done_pc"}, done_pc, pcv);
        chk({tag, " prf_we"}, {63'd0, prf_write_enable}, {63'd0, v.we});
        chk({tag, " set_rdy0"}, {63'd0, set_prn_ready[0]}, {63'd0, v.we});
        chk({tag, " set_rdy_hi"}, {62'd0, set_prn_ready[1], set_prn_ready[2]}, 64'd0);
        if (v.we) begin
            chk({tag, " prf_prn"}, {58'd0, prf_write_prn}, {58'd0, v.prn});
            chk({tag, " prf_data"}, prf_write_data, v.data);
            chk({tag, " set_prn0"}, {58'd0, set_prn[0]}, {58'd0, v.prn});
        end else begin
            chk({tag, " set_prn0_idle"}, {58'd0, set_prn[0]}, 64'd0);
        end
        @(posedge clk);
        #1;
        chk({tag, " done_one_cycle"}, {62'd0, done_valid, prf_write_enable}, 64'd0);
        chk({tag, " ready_after"}, {63'd0, fu_ready}, 64'd1);
    endtask

    vec_t tbl [7];
    vec_t rv;
    int   extra;

    initial begin
        rst_n = 1'b0;
        inst_valid = 1'b0;
        inst = '0; inst_id = '0; pc = '0;
        for (int k = 0; k < NO; k++) begin
            op[k] = '0;
            out_prn[k] = '0;
        end

        tbl[0] = '{inst:32'h9B000001, a:64'd3, b:64'd5, c:64'd7, prn:6'd12, we:1'b1, data:64'd22, fault:1'b0};
        tbl[1] = '{inst:32'h9B400003, a:64'hFFFFFFFFFFFFFFFF, b:64'hFFFFFFFFFFFFFFFF, c:64'd0, prn:6'd5, we:1'b1, data:64'd0, fault:1'b0};
        tbl[2] = '{inst:32'h9B400003, a:64'h8000000000000000, b:64'd2, c:64'd0, prn:6'd6, we:1'b1, data:64'hFFFFFFFFFFFFFFFF, fault:1'b0};
        tbl[3] = '{inst:32'h9BC00004, a:64'hFFFFFFFFFFFFFFFF, b:64'hFFFFFFFFFFFFFFFF, c:64'd0, prn:6'd7, we:1'b1, data:64'hFFFFFFFFFFFFFFFE, fault:1'b0};
        tbl[4] = '{inst:32'h9B008002, a:64'd2, b:64'd3, c:64'd1, prn:6'd8, we:1'b1, data:64'hFFFFFFFFFFFFFFFB, fault:1'b0};
        tbl[5] = '{inst:32'h00000000, a:64'd1, b:64'd2, c:64'd3, prn:6'd9, we:1'b0, data:64'd0, fault:1'b1};
        tbl[6] = '{inst:32'h9B00001F, a:64'd3, b:64'd5, c:64'd7, prn:6'd10, we:1'b0, data:64'd0, fault:1'b0};

        // Reset state
        #2;
        chk("rst fu_ready", {63'd0, fu_ready}, 64'd1);
        chk("rst outputs", {61'd0, done_valid, prf_write_enable, set_prn_ready[0]}, 64'd0);
        chk("rst prf_data", prf_write_data, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table
        for (int i = 0; i < 7; i++) begin
            run_vec(tbl[i], IB'(i + 1), 64'h1000 + 64'(i * 4), $sformatf("vec%0d", i), -1);
        end

        // Stray strobe during MUL must be ignored and yield exactly one completion
        run_vec(tbl[0], 6'd40, 64'hABCD0000, "dup", 5);
        extra = 0;
        repeat (25) begin
            @(posedge clk);
            #1 if (done_valid) extra++;
        end
        chk("dup extra_done", 64'(extra), 64'd0);

        // Reset at counter 8 aborts the in-flight instruction
        @(negedge clk);
        drive_issue(tbl[0], 6'd50, 64'h5000);
        @(posedge clk);
        #1 inst_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort outputs", {61'd0, done_valid, prf_write_enable, set_prn_ready[0]}, 64'd0);
        chk("abort fu_ready", {63'd0, fu_ready}, 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        extra = 0;
        repeat (30) begin
            @(posedge clk);
            #1 if (done_valid || prf_write_enable || set_prn_ready[0]) extra++;
        end
        chk("abort no_completion", 64'(extra), 64'd0);
        run_vec(tbl[4], 6'd51, 64'h5100, "post_abort", -1);

        // Randomized against the reference model
        for (int i = 0; i < 24; i++) begin
            logic [31:0] enc;
            logic [63:0] a, b, c;
            int sel;
            sel = $urandom_range(0, 4);
            case (sel)
                0: enc = 32'h9B000000 | ($urandom & 32'h001F7FFF);
                1: enc = 32'h9B008000 | ($urandom & 32'h001F7FFF);
                2: enc = 32'h9B400000 | ($urandom & 32'h001F7FFF);
                3: enc = 32'h9BC00000 | ($urandom & 32'h001F7FFF);
                default: enc = ($urandom & 32'h7FFFFFFF);
            endcase
            if ($urandom_range(0, 5) == 0) enc[4:0] = 5'd31;
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            c = {$urandom, $urandom};
            if ($urandom_range(0, 4) == 0) a = 64'h8000000000000000;
            if ($urandom_range(0, 4) == 0) b = 64'hFFFFFFFFFFFFFFFF;
            rv = model(enc, a, b, c, PB'($urandom));
            run_vec(rv, IB'($urandom), {$urandom, $urandom}, $sformatf("rnd%0d", i), -1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mul_fu.md
MUL_FU -- requirements
Module: mul_fu

Interface
REQ-001 SHALL have parameter INST_ID_BITS, default 6, instruction tag width.
REQ-002 SHALL have parameter PRN_BITS, default 6, physical register number width.
REQ-003 SHALL have parameter MAX_OPERANDS, default 3, operand/output slot count.
REQ-004 SHALL have ports, clock and reset first:
- clk  in  1  sole clock, all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- fu_ready  out  1  unit can accept an instruction.
- inst_valid  in  1  issue strobe, one cycle per instruction.
- inst_id  in  INST_ID_BITS  instruction tag.
- inst  in  32  raw AArch64 encoding.
- op[MAX_OPERANDS]  in  64 each  operand values: op[0]=Rn, op[1]=Rm, op[2]=Ra.
- out_prn[MAX_OPERANDS]  in  PRN_BITS each  destination PRNs; only slot 0 used.
- pc  in  64  instruction PC, captured for fault reporting.
- prf_write_enable  out  1  PRF write strobe.
- prf_write_prn  out  PRN_BITS  PRF write index.
- prf_write_data  out  64  PRF write data.
- set_prn_ready[MAX_OPERANDS]  out  1 each  wakeup broadcast valid.
- set_prn[MAX_OPERANDS]  out  PRN_BITS each  wakeup broadcast PRN.
- done_valid  out  1  completion pulse to ROB.
- done_inst_id  out  INST_ID_BITS  completed tag.
- done_fault  out  1  unsupported encoding.
- done_pc  out  64  PC of completed instruction.

Function
REQ-005 SHALL decode, mask 0xFFE08000: MADD 0x9B000000, MSUB 0x9B008000, SMULH 0x9B400000, UMULH 0x9BC00000; anything else is UNSUP.
REQ-006 SHALL compute MADD = op2 + low64(op0*op1), MSUB = op2 - low64(op0*op1), UMULH = high64(unsigned op0*op1), SMULH = high64(signed op0*op1); all arithmetic mod 2^64.
REQ-007 SHALL implement FSM IDLE -> MUL -> FIN -> WB -> IDLE.
REQ-008 SHALL drive fu_ready = (state==IDLE) && !inst_valid, combinationally, so an issue strobe blocks a second issue in the same cycle.
REQ-009 SHALL capture inst, inst_id, op, out_prn[0] and pc on the edge where state==IDLE and inst_valid=1; next state MUL, iteration counter 0.
REQ-010 SHALL ignore inst_valid in any state other than IDLE: no capture, no state change.
REQ-011 SHALL, in MUL, perform one radix-16 shift-add step per cycle on 64-bit magnitudes (128-bit accumulator) for 16 cycles; after the step with counter 15, go to FIN.
REQ-012 SHALL, for SMULH, multiply absolute values and negate the 128-bit product in FIN when operand signs differ; op0 = 0x8000000000000000 SHALL be handled as magnitude 2^63.
REQ-013 SHALL, in FIN, form the final 64-bit result, register all outputs, and go to WB.
REQ-014 SHALL, in WB only, assert done_valid, done_inst_id, done_fault and done_pc for exactly one cycle; state returns to IDLE on the following edge.
REQ-015 SHALL, in WB when Rd (inst[4:0]) != 31 and not UNSUP, assert prf_write_enable with prf_write_prn = captured out_prn[0] and prf_write_data = result; set_prn_ready[0]=1 with set_prn[0] = same PRN.
REQ-016 SHALL, when Rd==31 (XZR) or UNSUP, suppress PRF write and broadcast; done_valid still pulses; done_fault=1 only for UNSUP.
REQ-017 SHALL hold set_prn_ready[1..MAX_OPERANDS-1]=0 and set_prn[*]=0 whenever not broadcasting.
REQ-018 SHALL give fixed latency: outputs valid in the cycle after the 17th edge following capture; fu_ready high after the 18th edge.

Reset
REQ-019 SHALL, on rst_n low, asynchronously force state IDLE, counter 0, accumulator 0, and all outputs 0 except fu_ready, which follows REQ-008.
REQ-020 SHALL abort an in-flight instruction on reset: no done_valid, PRF write or broadcast for it after rst_n rises.

Structure
REQ-021 SHALL place mul_op_e (MADD, MSUB, SMULH, UMULH, UNSUP), the encoding mask and match constants, and the FSM state enum in shared package fu_pkg.
REQ-022 SHALL implement the per-cycle radix-16 step as sub-module mul_step (inputs: accumulator, multiplicand, 4-bit digit; output: next accumulator).

Verification
REQ-023 MADD op0=3, op1=5, op2=7, out_prn[0]=12, Rd=1 -> 17 cycles later: prf_write_data=22, prn 12, set_prn[0]=12, done one cycle.
REQ-024 SMULH op0=-1, op1=-1 -> result 0; SMULH op0=0x8000000000000000, op1=2 -> result 0xFFFFFFFFFFFFFFFF.
REQ-025 UMULH op0=op1=0xFFFFFFFFFFFFFFFF -> 0xFFFFFFFFFFFFFFFE; MSUB op0=2, op1=3, op2=1 -> 0xFFFFFFFFFFFFFFFB.
REQ-026 inst=0x00000000 -> done_fault=1, no PRF write or broadcast; MADD with Rd=31 -> done pulse, no write.
REQ-027 inst_valid in IDLE -> fu_ready=0 same cycle; second strobe during MUL -> ignored, single done.
REQ-028 rst_n low at counter 8 -> immediate IDLE, outputs 0, no completion afterward; next instruction completes normally.
